// File: rtl/pong_video_pkg.sv
// Shared video timing constants and the vertical count type for the Pong video chain.
package pong_video_pkg;
  localparam int H_TOTAL     = 455;
  localparam int V_TOTAL     = 262;
  localparam int VBLANK_END  = 16;
  localparam int VSYNC_START = 4;
  localparam int VSYNC_END   = 8;

  typedef logic [8:0] vcnt_t;
endpackage

// File: rtl/mod_n_counter.sv
// Enabled modulo-N counter; WRAP flags the enabled edge that returns Q to zero.
module mod_n_counter #(
  parameter int N = 262,
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         CLR_N,
  input  logic         EN,
  output logic [W-1:0] Q,
  output logic         WRAP
);
  logic [W-1:0] r_q;

  assign Q    = r_q;
  assign WRAP = EN && (r_q == W'(N - 1));

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)   r_q <= '0;
    else if (EN)  r_q <= WRAP ? '0 : r_q + 1'b1;
  end
endmodule

// File: rtl/vcounter.sv
// Vertical line counter: advances on HRESET, registered VRESET/VBLANK/VSYNC_N windows.
// Optional FRAME_CNT output enabled by defining VCOUNTER_FRAME_CNT_EN.
module vcounter #(
  parameter int V_TOTAL     = pong_video_pkg::V_TOTAL,
  parameter int VBLANK_END  = pong_video_pkg::VBLANK_END,
  parameter int VSYNC_START = pong_video_pkg::VSYNC_START,
  parameter int VSYNC_END   = pong_video_pkg::VSYNC_END
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       HRESET,
  output logic       _1V,
  output logic       _2V,
  output logic       _4V,
  output logic       _8V,
  output logic       _16V,
  output logic       _32V,
  output logic       _64V,
  output logic       _128V,
  output logic       _256V,
  output logic       _256V_N,
  output logic       VRESET,
  output logic       VRESET_N,
  output logic       VBLANK,
  output logic       VBLANK_N,
`ifdef VCOUNTER_FRAME_CNT_EN
  output logic [7:0] FRAME_CNT,
`endif
  output logic       VSYNC_N
);
  import pong_video_pkg::*;

  vcnt_t w_cnt;
  vcnt_t w_next;
  logic  w_wrap;
  logic  r_256v_n, r_vreset, r_vreset_n, r_vblank, r_vblank_n, r_vsync_n;

  mod_n_counter #(.N(V_TOTAL), .W($bits(vcnt_t))) u_cnt (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .EN    (HRESET),
    .Q     (w_cnt),
    .WRAP  (w_wrap)
  );

  // Decodes look at the value being loaded so the flags land on the same edge as the count.
  assign w_next = w_wrap ? '0 : w_cnt + 1'b1;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_256v_n   <= 1'b1;
      r_vreset   <= 1'b0;
      r_vreset_n <= 1'b1;
      r_vblank   <= 1'b1;
      r_vblank_n <= 1'b0;
      r_vsync_n  <= 1'b1;
    end else if (HRESET) begin
      r_256v_n   <= ~w_next[8];
      r_vreset   <=  (w_next == vcnt_t'(V_TOTAL - 1));
      r_vreset_n <= ~(w_next == vcnt_t'(V_TOTAL - 1));
      r_vblank   <=  (w_next < vcnt_t'(VBLANK_END));
      r_vblank_n <= ~(w_next < vcnt_t'(VBLANK_END));
      r_vsync_n  <= ~((w_next >= vcnt_t'(VSYNC_START)) && (w_next < vcnt_t'(VSYNC_END)));
    end
  end

`ifdef VCOUNTER_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)      r_frame_cnt <= '0;
    else if (w_wrap) r_frame_cnt <= r_frame_cnt + 8'd1;
  end
  assign FRAME_CNT = r_frame_cnt;
`endif

  assign {_256V, _128V, _64V, _32V, _16V, _8V, _4V, _2V, _1V} = w_cnt;
  assign _256V_N  = r_256v_n;
  assign VRESET   = r_vreset;
  assign VRESET_N = r_vreset_n;
  assign VBLANK   = r_vblank;
  assign VBLANK_N = r_vblank_n;
  assign VSYNC_N  = r_vsync_n;
endmodule
